instruction_prefetch_queue: RTL and testbench
=============================================

INSTRUCTION_PREFETCH_QUEUE -- requirements
Module: instruction_prefetch_queue

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - RESET_PC, 32'h0000_0000, first fetch address after reset.
  - DEPTH, 4, queue entries; power of 2, range 2..16.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, the single clock; all state updates on its rising edge.
  - reset, in, 1, asynchronous, active-low; 0 forces the reset state immediately.
  - mem_req, out, 1, fetch request, registered.
  - mem_addr, out, 32, fetch address, registered.
  - mem_ack, in, 1, memory accepts the request and returns data this cycle.
  - mem_rdata, in, 32, instruction word, valid when mem_req && mem_ack.
  - redirect, in, 1, flush the queue and restart fetch at redirect_pc.
  - redirect_pc, in, 32, new fetch address.
  - IRWrite, in, 1, consumer pops the head entry.
  - instr_valid, out, 1, queue not empty.
  - OldPC, out, 32, PC of the head entry.
  - Instruction, out, 32, raw head word.
  - Instruction_op, out, 7, head word bits [6:0].
  - Instruction_rd, out, 5, head word bits [11:7].
  - Instruction_func3, out, 3, head word bits [14:12].
  - Instruction_rs1, out, 5, head word bits [19:15].
  - Instruction_rs2, out, 5, head word bits [24:20].
  - Instruction_func7, out, 7, head word bits [31:25].
  - Instruction_extend, out, 25, head word bits [31:7].
  - count, out, $clog2(DEPTH+1), occupied entries.

Function
REQ-003 Each queue entry SHALL hold {pc[31:0], word[31:0]} in FIFO order; head fields SHALL be combinational from the head entry, and all Instruction*/OldPC outputs SHALL be 0 when count==0.
REQ-004 A pop SHALL occur when IRWrite && instr_valid && !redirect; IRWrite with count==0 SHALL be ignored.
REQ-005 The fetch FSM SHALL have the states IDLE, REQ and DRAIN; mem_req SHALL be 1 exactly in REQ and DRAIN.
REQ-006 The space condition SHALL be (count - pop) < DEPTH, evaluated in the current cycle.
REQ-007 IDLE -> REQ SHALL occur when space && !redirect; on the same edge mem_addr<=fetch_pc.
REQ-008 mem_addr SHALL stay stable while mem_req==1 and no ack has occurred.
REQ-009 In REQ, on mem_ack && !redirect the block SHALL:
  - push {mem_addr, mem_rdata};
  - set fetch_pc<=mem_addr+4, mod 2^32 wrap;
  - stay in REQ with mem_addr<=mem_addr+4 if space still holds after the push, else go to IDLE.
REQ-010 A push and a pop in the same cycle SHALL leave count unchanged; a push at count==DEPTH-1 with no pop SHALL make count==DEPTH.
REQ-011 redirect SHALL set count<=0 and fetch_pc<=redirect_pc, and SHALL take priority over push and pop.
REQ-012 Redirect transitions:
  - in REQ without mem_ack -> DRAIN;
  - in REQ with mem_ack -> data dropped, -> IDLE;
  - in IDLE -> IDLE;
  - in DRAIN -> stay in DRAIN.
REQ-013 In DRAIN, mem_req SHALL remain 1 at the old mem_addr until mem_ack, the returned data SHALL be discarded, and the next state SHALL be IDLE.
REQ-014 A write to the queue SHALL never be lost: an ack SHALL never occur without space, guaranteed by REQ-006/REQ-009 and a single outstanding request.
REQ-015 Read pointer, write pointer and count SHALL wrap modulo DEPTH without bubbles.

Reset
REQ-016 While reset==0 the block SHALL hold: state=IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, count=0, pointers=0, instr_valid=0, all Instruction*/OldPC=0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction without a push; fetch SHALL restart at RESET_PC in the first cycle after release that meets REQ-007.

Verification
REQ-018 Reset release, mem_ack always 1, IRWrite=0, DEPTH=4 -> pushes of PCs 0x0, 0x4, 0x8, 0xC; count=4; mem_req=0; OldPC=0x0.
REQ-019 Full queue, then IRWrite=1 held, mem_ack=1 -> one pop and one push per cycle; OldPC steps by 4; count never exceeds 4.
REQ-020 mem_ack delayed 3 cycles, redirect=1 to 0x100 in the first request cycle -> DRAIN; mem_addr unchanged until ack; that data discarded; next request at 0x100; first head OldPC=0x100.
REQ-021 redirect and mem_ack in the same cycle -> count=0, no push, next mem_addr=redirect_pc.
REQ-022 Head word 0xFE010113 -> op=0x13, rd=2, func3=0, rs1=2, rs2=0, func7=0x7F, extend=0x1FC0202.
REQ-023 reset pulsed low mid-REQ with count=2 -> outputs zero immediately; after release the first mem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding fetch engine that fills a
// small FIFO of {pc, word} entries and presents the head instruction decoded.
module instruction_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_rdata,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         IRWrite,
    output logic                         instr_valid,
    output logic [31:0]                  OldPC,
    output logic [31:0]                  Instruction,
    output logic [6:0]                   Instruction_op,
    output logic [4:0]                   Instruction_rd,
    output logic [2:0]                   Instruction_func3,
    output logic [4:0]                   Instruction_rs1,
    output logic [4:0]                   Instruction_rs2,
    output logic [6:0]                   Instruction_func7,
    output logic [24:0]                  Instruction_extend,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           mem_req_q, mem_req_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    pc_mem_q   [DEPTH];
    logic [31:0]    word_mem_q [DEPTH];

    logic           pop;
    logic           push;
    logic           space;
    logic           space_after_push;
    logic [CW:0]    occ_after_pop;
    logic [31:0]    head_pc;
    logic [31:0]    head_word;

    assign instr_valid = (count_q != '0);

    // Space is judged on occupancy net of this cycle's pop, so a full queue
    // being drained can launch the next fetch without a bubble.
    always_comb begin
        pop              = IRWrite && instr_valid && !redirect;
        push             = (state_q == REQ) && mem_ack && !redirect;
        occ_after_pop    = {1'b0, count_q} - {{CW{1'b0}}, pop};
        space            = occ_after_pop < DEPTH_W;
        space_after_push = (occ_after_pop + (CW + 1)'(1)) < DEPTH_W;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (space) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    fetch_pc_d = mem_addr_q + 32'd4;
                    if (space_after_push) begin
                        mem_addr_d = mem_addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // The stale request must complete before a new one may issue.
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d != IDLE);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: it is only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= mem_addr_q;
            word_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    always_comb begin
        head_pc   = '0;
        head_word = '0;
        if (instr_valid) begin
            head_pc   = pc_mem_q[rd_ptr_q];
            head_word = word_mem_q[rd_ptr_q];
        end
    end

    assign mem_req            = mem_req_q;
    assign mem_addr           = mem_addr_q;
    assign count              = count_q;
    assign OldPC              = head_pc;
    assign Instruction        = head_word;
    assign Instruction_op     = head_word[6:0];
    assign Instruction_rd     = head_word[11:7];
    assign Instruction_func3  = head_word[14:12];
    assign Instruction_rs1    = head_word[19:15];
    assign Instruction_rs2    = head_word[24:20];
    assign Instruction_func7  = head_word[31:25];
    assign Instruction_extend = head_word[31:7];

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instruction_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        IRWrite;
    logic        instr_valid;
    logic [31:0] OldPC;
    logic [31:0] Instruction;
    logic [6:0]  Instruction_op;
    logic [4:0]  Instruction_rd;
    logic [2:0]  Instruction_func3;
    logic [4:0]  Instruction_rs1;
    logic [4:0]  Instruction_rs2;
    logic [6:0]  Instruction_func7;
    logic [24:0] Instruction_extend;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'hFE01_0113;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = word_of(mem_addr);

    instruction_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .IRWrite(IRWrite), .instr_valid(instr_valid),
        .OldPC(OldPC), .Instruction(Instruction), .Instruction_op(Instruction_op),
        .Instruction_rd(Instruction_rd), .Instruction_func3(Instruction_func3),
        .Instruction_rs1(Instruction_rs1), .Instruction_rs2(Instruction_rs2),
        .Instruction_func7(Instruction_func7), .Instruction_extend(Instruction_extend),
        .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {pc, word}, plus request/drain flags.
    logic [63:0] mq[$];
    bit          m_req   = 1'b0;
    bit          m_drain = 1'b0;
    logic [31:0] m_addr  = RESET_PC;
    logic [31:0] m_next  = RESET_PC;

    always @(posedge clk) begin : model
        int          n;
        bit          do_pop;
        bit          do_push;
        bit          ack;
        logic [63:0] ent;
        logic [31:0] h_pc;
        logic [31:0] h_w;
        if (!reset) begin
            mq.delete();
            m_req   = 1'b0;
            m_drain = 1'b0;
            m_addr  = RESET_PC;
            m_next  = RESET_PC;
        end else begin
            n       = mq.size();
            do_pop  = IRWrite && (n > 0) && !redirect;
            ack     = m_req && mem_ack;
            do_push = 1'b0;
            ent     = '0;
            if (!m_req) begin
                if (redirect) m_next = redirect_pc;
                else if ((n - int'(do_pop)) < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_next;
                end
            end else if (m_drain) begin
                if (redirect) m_next = redirect_pc;
                if (ack) begin
                    m_req   = 1'b0;
                    m_drain = 1'b0;
                end
            end else if (redirect) begin
                m_next = redirect_pc;
                if (ack) m_req = 1'b0;
                else     m_drain = 1'b1;
            end else if (ack) begin
                do_push = 1'b1;
                ent     = {m_addr, word_of(m_addr)};
                m_next  = m_addr + 32'd4;
                if ((n - int'(do_pop) + 1) < DEPTH) m_addr = m_addr + 32'd4;
                else                                 m_req  = 1'b0;
            end
            if (redirect) mq.delete();
            else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(ent);
            end
        end
        #1;
        if (reset) begin
            h_pc = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            h_w  = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
            chk("m.mem_req", {31'b0, mem_req}, {31'b0, m_req});
            chk("m.mem_addr", mem_addr, m_addr);
            chk("m.count", {29'b0, count}, mq.size());
            chk("m.instr_valid", {31'b0, instr_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("m.OldPC", OldPC, h_pc);
            chk("m.Instruction", Instruction, h_w);
            chk("m.op", {25'b0, Instruction_op}, h_w & 32'h7F);
            chk("m.rd", {27'b0, Instruction_rd}, (h_w >> 7) & 32'h1F);
            chk("m.func3", {29'b0, Instruction_func3}, (h_w >> 12) & 32'h7);
            chk("m.rs1", {27'b0, Instruction_rs1}, (h_w >> 15) & 32'h1F);
            chk("m.rs2", {27'b0, Instruction_rs2}, (h_w >> 20) & 32'h1F);
            chk("m.func7", {25'b0, Instruction_func7}, h_w >> 25);
            chk("m.extend", {7'b0, Instruction_extend}, h_w >> 7);
        end
    end

    initial begin
        reset       = 1'b0;
        mem_ack     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        IRWrite     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.count", {29'b0, count}, 32'd0);
        chk("rst.mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst.mem_addr", mem_addr, RESET_PC);
        chk("rst.instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst.Instruction", Instruction, 32'd0);

        // Fill from reset with ack always high.
        reset   = 1'b1;
        mem_ack = 1'b1;
        repeat (8) @(negedge clk);
        chk("fill.count", {29'b0, count}, 32'd4);
        chk("fill.mem_req", {31'b0, mem_req}, 32'd0);
        chk("fill.OldPC", OldPC, 32'h0);
        chk("fill.Instruction", Instruction, 32'h0000_FFFF);

        // Streaming: one pop and one push per cycle.
        IRWrite = 1'b1;
        repeat (6) @(negedge clk);
        chk("stream.OldPC", OldPC, 32'h18);
        chk("stream.count", {29'b0, count}, 32'd3);
        chk("stream.mem_addr", mem_addr, 32'h24);

        // Redirect in the first cycle of a slow request.
        IRWrite     = 1'b0;
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        chk("drain.mem_req", {31'b0, mem_req}, 32'd1);
        chk("drain.addr0", mem_addr, 32'h24);
        chk("drain.count", {29'b0, count}, 32'd0);
        @(negedge clk);
        chk("drain.addr1", mem_addr, 32'h24);
        @(negedge clk);
        chk("drain.addr2", mem_addr, 32'h24);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("drain.done_req", {31'b0, mem_req}, 32'd0);
        chk("drain.discard", {29'b0, count}, 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("redir.addr", mem_addr, 32'h100);
        chk("redir.req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("redir.OldPC", OldPC, 32'h100);
        chk("redir.count", {29'b0, count}, 32'd1);

        // Redirect coinciding with an ack drops the data.
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("coinc.count", {29'b0, count}, 32'd0);
        chk("coinc.req", {31'b0, mem_req}, 32'd0);
        chk("coinc.valid", {31'b0, instr_valid}, 32'd0);
        redirect = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        chk("coinc.addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("dec.op", {25'b0, Instruction_op}, 32'h13);
        chk("dec.rd", {27'b0, Instruction_rd}, 32'd2);
        chk("dec.func3", {29'b0, Instruction_func3}, 32'd0);
        chk("dec.rs1", {27'b0, Instruction_rs1}, 32'd2);
        chk("dec.rs2", {27'b0, Instruction_rs2}, 32'd0);
        chk("dec.func7", {25'b0, Instruction_func7}, 32'h7F);
        chk("dec.extend", {7'b0, Instruction_extend}, 32'h1FC0202);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mid.count", {29'b0, count}, 32'd2);
        chk("mid.req", {31'b0, mem_req}, 32'd1);

        // Asynchronous reset in the middle of a request.
        #2 reset = 1'b0;
        #1;
        chk("arst.count", {29'b0, count}, 32'd0);
        chk("arst.req", {31'b0, mem_req}, 32'd0);
        chk("arst.valid", {31'b0, instr_valid}, 32'd0);
        chk("arst.OldPC", OldPC, 32'd0);
        chk("arst.Instruction", Instruction, 32'd0);
        chk("arst.addr", mem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        chk("rel.addr", mem_addr, RESET_PC);
        chk("rel.req", {31'b0, mem_req}, 32'd1);
        IRWrite = 1'b1;
        repeat (12) @(negedge clk);
        IRWrite = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
